// File: rtl/code_seq_pkg.sv
// Shared types for the class-code sequence detector.
// Code encodings and detector FSM states.
package code_seq_pkg;

  typedef enum logic [1:0] {
    CODE_ZERO    = 2'd0,
    CODE_ONE     = 2'd1,
    CODE_OTHER   = 2'd2,
    CODE_ILLEGAL = 2'd3
  } code_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SAW0  = 2'd1,
    S_SAW01 = 2'd2
  } seq_state_t;

endpackage

// File: rtl/code_seq_detector_sat_counter.sv
// Saturating event counter with a registered at-max flag.
// sat rises in the same cycle the count first reads the max.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_d;

  // next count: step only below max
  always_comb begin
    cnt_d = count;
    if (inc && (count != MAX)) begin
      cnt_d = count + W'(1);
    end
  end

  // count and flag registers: reset > clr > update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= cnt_d;
      sat   <= (cnt_d == MAX);
    end
  end

endmodule

// File: rtl/code_seq_detector.sv
// Detects valid code sequence 0,1,2; pulses and counts matches.
// Optional sticky illegal-code flag when CODE_ERR_EN is defined.
module code_seq_detector
  import code_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_valid,
  input  logic [1:0]       code,
  input  logic             clr,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
`ifdef CODE_ERR_EN
  output logic             count_sat,
  output logic             code_err
`else
  output logic             count_sat
`endif
);

  seq_state_t state_q;
  seq_state_t state_d;
  code_t      c_in;
  logic       hit;

  // next state and completion detect
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    c_in    = code_t'(code);
    if (code_valid) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = (c_in == CODE_ZERO) ? S_SAW0 : S_IDLE;
        end
        S_SAW0: begin
          unique case (c_in)
            CODE_ZERO: state_d = S_SAW0;
            CODE_ONE:  state_d = S_SAW01;
            default:   state_d = S_IDLE;
          endcase
        end
        S_SAW01: begin
          unique case (c_in)
            CODE_OTHER: begin
              state_d = S_IDLE;
              hit     = 1'b1;
            end
            CODE_ZERO:  state_d = S_SAW0;
            default:    state_d = S_IDLE;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and pulse registers: reset > clr > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      match_pulse <= 1'b0;
    end else if (clr) begin
      state_q     <= S_IDLE;
      match_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_pulse <= hit;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit),
    .clr  (clr),
    .count(match_count),
    .sat  (count_sat)
  );

`ifdef CODE_ERR_EN
  // sticky flag for any valid illegal code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_err <= 1'b0;
    end else if (clr) begin
      code_err <= 1'b0;
    end else if (code_valid && (c_in == CODE_ILLEGAL)) begin
      code_err <= 1'b1;
    end
  end
`endif

endmodule
